// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and helpers for the FND scan driver.
//   - GLYPH_* : active-low 7-segment patterns, bit order g..a
//   - SEG_DARK : all segments off
//   - COM_OFF / com_on() : active-low digit-common patterns (sliced by the user)
//   - glyph_decode() : 4-bit code -> segment pattern, with hex-mode select
package fnd_pkg;

  localparam int MAX_DIGITS = 32;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1011000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0011000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  localparam logic [6:0] SEG_DARK = 7'h7F;

  // All commons released (active-low); slice to the digit count in use.
  localparam logic [MAX_DIGITS-1:0] COM_OFF = '1;

  // Only common k driven low.
  function automatic logic [MAX_DIGITS-1:0] com_on(input int k);
    com_on = ~(MAX_DIGITS'(1) << k);
  endfunction

  // Without hex mode every code A-F collapses onto the "F" glyph.
  function automatic logic [6:0] glyph_decode(input logic [3:0] code, input logic hex);
    case (code)
      4'h0: glyph_decode = GLYPH_0;
      4'h1: glyph_decode = GLYPH_1;
      4'h2: glyph_decode = GLYPH_2;
      4'h3: glyph_decode = GLYPH_3;
      4'h4: glyph_decode = GLYPH_4;
      4'h5: glyph_decode = GLYPH_5;
      4'h6: glyph_decode = GLYPH_6;
      4'h7: glyph_decode = GLYPH_7;
      4'h8: glyph_decode = GLYPH_8;
      4'h9: glyph_decode = GLYPH_9;
      4'hA: glyph_decode = hex ? GLYPH_A : GLYPH_F;
      4'hB: glyph_decode = hex ? GLYPH_B : GLYPH_F;
      4'hC: glyph_decode = hex ? GLYPH_C : GLYPH_F;
      4'hD: glyph_decode = hex ? GLYPH_D : GLYPH_F;
      4'hE: glyph_decode = hex ? GLYPH_E : GLYPH_F;
      default: glyph_decode = GLYPH_F;
    endcase
  endfunction

endpackage

// File: rtl/fnd_scan_driver_if.sv
// fnd_scan_driver_if: bundle between the value source (master) and the
// FND scan driver (slave).
//   i_Data  : 4 bits per digit, digit 0 in bits [3:0]
//   i_Load  : one-cycle capture strobe for i_Data
//   i_Blank : per-digit force dark (live)
//   i_Blink : per-digit blink enable (live)
//   i_LZB   : leading-zero blanking enable
//   o_FND   : segments g..a, active-low
//   o_Com   : digit commons, active-low one-hot
//   o_Frame : pulse on the first output cycle of digit 0's slot
interface fnd_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] i_Data;
  logic                    i_Load;
  logic [NUM_DIGITS-1:0]   i_Blank;
  logic [NUM_DIGITS-1:0]   i_Blink;
  logic                    i_LZB;
  logic [6:0]              o_FND;
  logic [NUM_DIGITS-1:0]   o_Com;
  logic                    o_Frame;

  modport master (
    output i_Data, i_Load, i_Blank, i_Blink, i_LZB,
    input  o_FND, o_Com, o_Frame
  );

  modport slave (
    input  i_Data, i_Load, i_Blank, i_Blink, i_LZB,
    output o_FND, o_Com, o_Frame
  );
endinterface

// File: rtl/fnd_decode.sv
// fnd_decode: combinational 4-bit code to active-low 7-segment decoder.
//   code : digit value
//   seg  : segments g..a, active-low
module fnd_decode
  import fnd_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = glyph_decode(code, HEX_MODE != 0);

endmodule

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: time-multiplexed multi-digit 7-segment driver with a
// double-buffered value, per-digit blank/blink, leading-zero blanking.
//   i_Clk : system clock
//   i_Rst : asynchronous reset, active-low
//   bus   : fnd_scan_driver_if slave (data/load/blank/blink/LZB in,
//           segments/commons/frame pulse out)
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 250,
  parameter int HEX_MODE     = 0
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  fnd_scan_driver_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         disp;
  logic [DW-1:0]         pend;
  logic                  upd;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_on;

  logic [6:0]            fnd_q;
  logic [NUM_DIGITS-1:0] com_q;
  logic                  frame_q;

  logic                  cnt_tc;
  logic                  frame_end;
  logic [3:0]            cur_digit;
  logic                  cur_dark;
  logic [6:0]            cur_seg;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;
  logic [MAX_DIGITS-1:0] com_sel;

  assign cnt_tc    = (cnt == CNT_LAST);
  assign frame_end = cnt_tc && (idx == IDX_LAST);

  // lead_zero[k]: display digits k..top are all zero. Digit 0 is excluded so
  // a value of zero still shows a single "0".
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run & (disp[4*k +: 4] == 4'd0);
      lead_zero[k] = zero_run;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_dark  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_digit = disp[4*k +: 4];
        cur_dark  = bus.i_Blank[k]
                  | (bus.i_Blink[k] & ~blink_on)
                  | (bus.i_LZB & lead_zero[k]);
      end
    end
  end

  always_comb begin
    com_sel = com_on(int'(idx));
  end

  fnd_decode #(
    .HEX_MODE (HEX_MODE)
  ) u_decode (
    .code (cur_digit),
    .seg  (cur_seg)
  );

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_tc) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load landing on the frame boundary bypasses the pending stage so it
  // shows in the frame that is just starting.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      disp <= '0;
      pend <= '0;
      upd  <= 1'b0;
    end else if (bus.i_Load && frame_end) begin
      disp <= bus.i_Data;
      upd  <= 1'b0;
    end else if (bus.i_Load) begin
      pend <= bus.i_Data;
      upd  <= 1'b1;
    end else if (frame_end && upd) begin
      disp <= pend;
      upd  <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // First cycle of each slot releases every common so the segment bus can
  // settle on the new glyph without ghosting onto the previous digit.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      fnd_q   <= SEG_DARK;
      com_q   <= COM_OFF[NUM_DIGITS-1:0];
      frame_q <= 1'b0;
    end else begin
      fnd_q   <= cur_dark ? SEG_DARK : cur_seg;
      com_q   <= (cnt == '0) ? COM_OFF[NUM_DIGITS-1:0] : com_sel[NUM_DIGITS-1:0];
      frame_q <= (cnt == '0) && (idx == '0);
    end
  end

  assign bus.o_FND   = fnd_q;
  assign bus.o_Com   = com_q;
  assign bus.o_Frame = frame_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
module tb_fnd_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FL = ND * SD;

  localparam logic [6:0] G0   = 7'b1000000;
  localparam logic [6:0] G1   = 7'b1111001;
  localparam logic [6:0] G2   = 7'b0100100;
  localparam logic [6:0] G3   = 7'b0110000;
  localparam logic [6:0] G4   = 7'b0011001;
  localparam logic [6:0] G5   = 7'b0010010;
  localparam logic [6:0] G9   = 7'b0011000;
  localparam logic [6:0] GF   = 7'b0001110;
  localparam logic [6:0] GA   = 7'b0001000;
  localparam logic [6:0] DARK = 7'b1111111;

  logic clk;
  logic rst;
  logic [15:0] data;
  logic load;
  logic [3:0] blank;
  logic [3:0] blink;
  logic lzb;

  int n_checks;
  int n_fail;

  logic [6:0] fnd_s  [FL];
  logic [6:0] fnd1_s [FL];
  logic [3:0] com_s  [FL];
  logic       frm_s  [FL];

  fnd_scan_driver_if #(.NUM_DIGITS(ND)) bus0 ();
  fnd_scan_driver_if #(.NUM_DIGITS(ND)) bus1 ();

  assign bus0.i_Data  = data;
  assign bus0.i_Load  = load;
  assign bus0.i_Blank = blank;
  assign bus0.i_Blink = blink;
  assign bus0.i_LZB   = lzb;
  assign bus1.i_Data  = data;
  assign bus1.i_Load  = load;
  assign bus1.i_Blank = blank;
  assign bus1.i_Blink = blink;
  assign bus1.i_LZB   = lzb;

  fnd_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_MODE(0)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus0)
  );

  fnd_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_MODE(1)
  ) dut_hex (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus0.o_Frame && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.o_Frame) check("frame_timeout", 32'(bus0.o_Frame), 32'd1);
  endtask

  // Captures one full frame starting at the next o_Frame; optional loads are
  // driven at the negedge of the given output cycle (seen at the next posedge).
  task automatic capture_frame(input int lc1, input logic [15:0] v1,
                               input int lc2, input logic [15:0] v2);
    wait_frame();
    for (int c = 0; c < FL; c++) begin
      if (c > 0) @(negedge clk);
      fnd_s[c]  = bus0.o_FND;
      fnd1_s[c] = bus1.o_FND;
      com_s[c]  = bus0.o_Com;
      frm_s[c]  = bus0.o_Frame;
      if (c == lc1) begin
        data = v1;
        load = 1'b1;
      end else if (c == lc2) begin
        data = v2;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e [ND];
    logic [3:0] exp_com;
    int c;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int s = 0; s < ND; s++) begin
      for (int j = 0; j < SD; j++) begin
        c = s * SD + j;
        exp_com = 4'hF;
        if (j != 0) exp_com[s] = 1'b0;
        check($sformatf("%s_d%0d_c%0d_fnd", tag, s, j), 32'(fnd_s[c]), 32'(e[s]));
        check($sformatf("%s_d%0d_c%0d_com", tag, s, j), 32'(com_s[c]), 32'(exp_com));
        check($sformatf("%s_d%0d_c%0d_frame", tag, s, j), 32'(frm_s[c]), (c == 0) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b0;
    data  = '0;
    load  = 1'b0;
    blank = '0;
    blink = '0;
    lzb   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_hold_fnd", 32'(bus0.o_FND), 32'h7F);
    check("rst_hold_com", 32'(bus0.o_Com), 32'hF);
    rst = 1'b1;
    @(negedge clk);
    check("first_frame", 32'(bus0.o_Frame), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_com", 32'(bus0.o_Com), 32'hE);
    check("pre_rst_fnd", 32'(bus0.o_FND), 32'(G0));
    #2 rst = 1'b0;
    #1;
    check("async_rst_fnd", 32'(bus0.o_FND), 32'h7F);
    check("async_rst_com", 32'(bus0.o_Com), 32'hF);
    check("async_rst_frame", 32'(bus0.o_Frame), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Mid-frame load does not disturb the current frame.
    capture_frame(5, 16'h1234, -1, 16'h0);
    check_frame("f0_zero", G0, G0, G0, G0);
    capture_frame(5, 16'h0050, -1, 16'h0);
    check_frame("f1_1234", G4, G3, G2, G1);
    lzb = 1'b1;
    capture_frame(5, 16'h000A, -1, 16'h0);
    check_frame("f2_lzb_0050", G0, G5, DARK, DARK);
    capture_frame(-1, 16'h0, -1, 16'h0);
    check_frame("f3_lzb_000a", GF, DARK, DARK, DARK);
    check("hex_digit0_a", 32'(fnd1_s[1]), 32'(GA));
    check("hex_digit1_dark", 32'(fnd1_s[5]), 32'(DARK));
    lzb = 1'b0;

    // Pending 1111 is overridden by a load on the boundary cycle (cycle 14).
    capture_frame(5, 16'h1111, 14, 16'h9999);
    check_frame("f4_000a", GF, G0, G0, G0);
    check("hex_digit0_a_nolzb", 32'(fnd1_s[2]), 32'(GA));
    capture_frame(-1, 16'h0, -1, 16'h0);
    check_frame("f5_collide", G9, G9, G9, G9);
    capture_frame(-1, 16'h0, -1, 16'h0);
    check_frame("f6_no_reupdate", G9, G9, G9, G9);

    // Blink/blank counted from a fresh reset.
    blink = 4'b0001;
    blank = 4'b1000;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int f = 0; f < 6; f++) begin
      capture_frame(-1, 16'h0, -1, 16'h0);
      check_frame($sformatf("blink_f%0d", f),
                  (f == 2 || f == 3) ? DARK : G0, G0, G0, DARK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
